// File: rtl/sc_io_input.sv
// Memory-mapped switch/key input port: sync, debounce, sticky events, read-to-clear.
// Optional SC_IO_INPUT_IRQ_EN macro enables a registered key-event interrupt.
module sc_io_input #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [9:0]  sw_in,
    input  logic [3:1]  key_in,
    input  logic [31:0] addr,
    input  logic        rd_en,
    output logic [31:0] dataout,
    output logic        hit,
    output logic        irq
);

    localparam int PW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(DEBOUNCE_CYCLES - 1);

    localparam logic [31:0] A_SW     = 32'hFFFF_FF00;
    localparam logic [31:0] A_KEY    = 32'hFFFF_FF10;
    localparam logic [31:0] A_KEYEVT = 32'hFFFF_FF90;
    localparam logic [31:0] A_SWCHG  = 32'hFFFF_FFA0;

    logic [PW-1:0] ps_cnt;
    logic          tick;

    logic [9:0] sw_s1, sw_s2;
    logic [9:0] sw_h0, sw_h1, sw_h2;
    logic [9:0] sw_db, sw_db_nxt;
    logic [3:1] key_s1, key_s2;
    logic [3:1] key_h0, key_h1, key_h2;
    logic [3:1] key_db, key_db_nxt;

    logic [3:1] key_evt;
    logic       sw_chg;
    logic [3:1] key_fall;
    logic       sw_changed;

    logic [31:0] rd_data;
    logic        rd_hit;
    logic        clr_key;
    logic        clr_sw;

    assign tick = (ps_cnt == PS_MAX);

    // New history after a tick is {s2, h0, h1}; update only on full agreement.
    always_comb begin
        sw_db_nxt  = sw_db;
        key_db_nxt = key_db;
        if (tick) begin
            sw_db_nxt  = (sw_db | (sw_s2 & sw_h0 & sw_h1))
                       & (sw_s2 | sw_h0 | sw_h1);
            key_db_nxt = (key_db | (key_s2 & key_h0 & key_h1))
                       & (key_s2 | key_h0 | key_h1);
        end
    end

    assign key_fall   = key_db & ~key_db_nxt;
    assign sw_changed = |(sw_db ^ sw_db_nxt);

    always_comb begin
        rd_data = 32'h0;
        rd_hit  = 1'b0;
        clr_key = 1'b0;
        clr_sw  = 1'b0;
        unique case (1'b1)
            (addr == A_SW): begin
                rd_data = {22'b0, sw_db};
                rd_hit  = 1'b1;
            end
            (addr == A_KEY): begin
                rd_data = {28'b0, key_db, 1'b1};
                rd_hit  = 1'b1;
            end
            (addr == A_KEYEVT): begin
                rd_data = {28'b0, key_evt, 1'b0};
                rd_hit  = 1'b1;
                clr_key = rd_en;
            end
            (addr == A_SWCHG): begin
                rd_data = {31'b0, sw_chg};
                rd_hit  = 1'b1;
                clr_sw  = rd_en;
            end
            default: begin
                rd_data = 32'h0;
                rd_hit  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ps_cnt  <= '0;
            sw_s1   <= '0;
            sw_s2   <= '0;
            sw_h0   <= '0;
            sw_h1   <= '0;
            sw_h2   <= '0;
            sw_db   <= '0;
            key_s1  <= '1;
            key_s2  <= '1;
            key_h0  <= '1;
            key_h1  <= '1;
            key_h2  <= '1;
            key_db  <= '1;
            key_evt <= '0;
            sw_chg  <= 1'b0;
            dataout <= '0;
            hit     <= 1'b0;
        end else begin
            ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
            sw_s1  <= sw_in;
            sw_s2  <= sw_s1;
            key_s1 <= key_in;
            key_s2 <= key_s1;
            if (tick) begin
                sw_h0  <= sw_s2;
                sw_h1  <= sw_h0;
                sw_h2  <= sw_h1;
                key_h0 <= key_s2;
                key_h1 <= key_h0;
                key_h2 <= key_h1;
            end
            sw_db  <= sw_db_nxt;
            key_db <= key_db_nxt;
            // A new event in the clearing cycle survives the clear.
            key_evt <= (key_evt & ~{3{clr_key}}) | key_fall;
            sw_chg  <= (sw_chg & ~clr_sw) | sw_changed;
            if (rd_en) begin
                dataout <= rd_data;
                hit     <= rd_hit;
            end
        end
    end

`ifdef SC_IO_INPUT_IRQ_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) irq <= 1'b0;
        else         irq <= |key_evt;
    end
`else
    assign irq = 1'b0;
`endif

    logic unused_hist;
    assign unused_hist = ^{sw_h2, key_h2};

endmodule

// File: tb/tb_sc_io_input.sv
// Directed bench for sc_io_input with a short debounce period.
module tb_sc_io_input;

    localparam int D = 4;
`ifdef SC_IO_INPUT_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        resetn;
    logic [9:0]  sw_in;
    logic [3:1]  key_in;
    logic [31:0] addr;
    logic        rd_en;
    logic [31:0] dataout;
    logic        hit;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    sc_io_input #(.DEBOUNCE_CYCLES(D)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .sw_in   (sw_in),
        .key_in  (key_in),
        .addr    (addr),
        .rd_en   (rd_en),
        .dataout (dataout),
        .hit     (hit),
        .irq     (irq)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] a);
        rd_en = 1'b1;
        addr  = a;
        step();
        rd_en = 1'b0;
        addr  = 32'h0;
    endtask

    // Edge at which a change driven after edge e reaches the debounced value.
    function automatic int t3_of(input int e);
        int t1;
        t1 = ((e + 3 + D - 1) / D) * D;
        return t1 + 2 * D;
    endfunction

    initial begin
        int e, t3a, t3b;
        resetn = 1'b0;
        rd_en  = 1'b1;
        addr   = 32'hFFFF_FF10;
        sw_in  = 10'($urandom);
        key_in = 3'($urandom);
        repeat (3) @(posedge clock);
        #1;
        chk("rst_dataout", dataout, 32'h0);
        chk("rst_hit", {31'b0, hit}, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        sw_in  = 10'h0;
        key_in = 3'b111;
        rd_en  = 1'b0;
        addr   = 32'h0;
        resetn = 1'b1;
        cyc    = 0;

        do_read(32'hFFFF_FF00);
        chk("rd_sw0", dataout, 32'h0);
        chk("rd_sw0_hit", {31'b0, hit}, 32'h1);
        do_read(32'hFFFF_FF10);
        chk("rd_key_idle", dataout, 32'hF);
        addr = 32'hFFFF_FF00;
        step();
        step();
        chk("hold_data", dataout, 32'hF);
        chk("hold_hit", {31'b0, hit}, 32'h1);
        addr = 32'h0;

        for (int i = 0; i < 40; i++) begin
            sw_in = (((i / 3) % 2) == 1) ? 10'h3FF : 10'h000;
            if (i % 10 == 9) begin
                rd_en = 1'b1;
                addr  = 32'hFFFF_FF00;
            end
            step();
            if (i % 10 == 9) begin
                rd_en = 1'b0;
                chk("bounce_sw", dataout, 32'h0);
            end
        end
        sw_in = 10'h2A5;
        repeat (15) step();
        do_read(32'hFFFF_FF00);
        chk("settled_sw", dataout, 32'h2A5);
        do_read(32'hFFFF_FFA0);
        chk("sw_chg_set", dataout, 32'h1);
        do_read(32'hFFFF_FFA0);
        chk("sw_chg_clr", dataout, 32'h0);

        e = cyc;
        key_in = 3'b101;
        repeat (16) step();
        do_read(32'hFFFF_FF10);
        chk("key2_db", dataout, 32'hB);
        do_read(32'hFFFF_FF90);
        chk("key2_evt", dataout, 32'h4);
        do_read(32'hFFFF_FF90);
        chk("key2_reread", dataout, 32'h0);
        while (cyc < e + 30) step();
        key_in = 3'b111;
        repeat (16) step();
        do_read(32'hFFFF_FF90);
        chk("release_evt", dataout, 32'h0);
        do_read(32'hFFFF_FF10);
        chk("release_db", dataout, 32'hF);

        e = cyc;
        key_in = 3'b110;
        t3a = t3_of(e);
        while (cyc < t3a) step();
        chk("irq_pre", {31'b0, irq}, 32'h0);
        step();
        chk("irq_rise", {31'b0, irq}, {31'b0, IRQ_ON});
        do_read(32'hFFFF_FF10);
        chk("key1_db", dataout, 32'hD);

        e = cyc;
        key_in = 3'b010;
        t3b = t3_of(e);
        chk("coll_sched", {31'b0, cyc < t3b - 1}, 32'h1);
        while (cyc < t3b - 1) step();
        do_read(32'hFFFF_FF90);
        chk("coll_read", dataout, 32'h2);
        chk("coll_irq", {31'b0, irq}, {31'b0, IRQ_ON});
        do_read(32'hFFFF_FF20);
        chk("unmap_data", dataout, 32'h0);
        chk("unmap_hit", {31'b0, hit}, 32'h0);
        do_read(32'hFFFF_FF90);
        chk("coll_next", dataout, 32'h8);
        chk("coll_next_hit", {31'b0, hit}, 32'h1);
        chk("irq_hold", {31'b0, irq}, {31'b0, IRQ_ON});
        step();
        chk("irq_fall", {31'b0, irq}, 32'h0);
        do_read(32'hFFFF_FF10);
        chk("key13_db", dataout, 32'h5);

        key_in = 3'b111;
        repeat (20) step();
        key_in = 3'b011;
        repeat (16) step();
        resetn = 1'b0;
        #1;
        chk("mid_rst_data", dataout, 32'h0);
        chk("mid_rst_hit", {31'b0, hit}, 32'h0);
        chk("mid_rst_irq", {31'b0, irq}, 32'h0);
        key_in = 3'b111;
        sw_in  = 10'h0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        cyc    = 0;
        do_read(32'hFFFF_FF90);
        chk("post_rst_evt", dataout, 32'h0);
        do_read(32'hFFFF_FF10);
        chk("post_rst_key", dataout, 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
